// File: rtl/ddr_chk_pkg.sv
// Shared types and helpers for the DDR3 read-back checker.
// Holds the checker FSM encoding, error counter width and saturating increment.
package ddr_chk_pkg;

  localparam int unsigned ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLvl,
    StRead,
    StDrain,
    StDone
  } chk_state_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] val);
    return (val == {ERR_CNT_W{1'b1}}) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/ddr_chk_pattern_gen.sv
// Incrementing reference pattern for the read checker: reloads the start value on
// load and steps by one (wrapping modulo 2^DATA_WIDTH) on every compared word.
module ddr_chk_pattern_gen #(
  parameter int unsigned           DATA_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0] PATTERN_START = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] expected
);

  logic [DATA_WIDTH-1:0] expected_q, expected_d;

  always_comb begin
    expected_d = expected_q;
    if (load) begin
      expected_d = PATTERN_START;
    end else if (advance) begin
      expected_d = expected_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_q <= PATTERN_START;
    end else begin
      expected_q <= expected_d;
    end
  end

  assign expected = expected_q;

endmodule

// File: rtl/ddr_rd_checker.sv
// Read-side burst checker for the DDR3 read-back FIFO: waits for a full burst,
// drains it and compares every word against an incrementing reference pattern.
module ddr_rd_checker
  import ddr_chk_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 16,
  parameter int unsigned           LEVEL_WIDTH   = 14,
  parameter int unsigned           BURST_LEN     = 256,
  parameter int unsigned           TOTAL_WORDS   = 8192,
  parameter logic [DATA_WIDTH-1:0] PATTERN_START = '0
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   start,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   chk_busy,
  output logic                   chk_done,
  output logic                   err_flag,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic [LEVEL_WIDTH:0]   word_cnt,
  output logic [LEVEL_WIDTH:0]   first_err_idx,
  output logic [DATA_WIDTH-1:0]  first_err_data
);

  localparam logic [LEVEL_WIDTH-1:0] BurstLenC   = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [LEVEL_WIDTH:0]   TotalWordsC = (LEVEL_WIDTH + 1)'(TOTAL_WORDS);

  chk_state_e             state_q, state_d;
  logic [LEVEL_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic [LEVEL_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [LEVEL_WIDTH:0]   first_err_idx_q, first_err_idx_d;
  logic [DATA_WIDTH-1:0]  first_err_data_q, first_err_data_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   err_flag_q, err_flag_d;
  logic                   chk_busy_q, chk_done_q;
  logic                   rd_vld_q;
  logic                   acc;
  logic                   pat_load;
  logic [DATA_WIDTH-1:0]  expected;

  // Combinational so a read is never issued in a cycle the FIFO reports empty.
  assign fifo_rd_en = (state_q == StRead) & ~fifo_rd_empty & (burst_cnt_q < BurstLenC);
  assign acc        = fifo_rd_en & ~fifo_rd_empty;

  ddr_chk_pattern_gen #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PATTERN_START(PATTERN_START)
  ) u_pattern_gen (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .load    (pat_load),
    .advance (rd_vld_q),
    .expected(expected)
  );

  always_comb begin
    state_d          = state_q;
    burst_cnt_d      = burst_cnt_q;
    word_cnt_d       = word_cnt_q;
    err_flag_d       = err_flag_q;
    err_cnt_d        = err_cnt_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    pat_load         = 1'b0;

    // Compare the word returned by the read accepted in the previous cycle.
    if (rd_vld_q) begin
      word_cnt_d = word_cnt_q + 1'b1;
      if (fifo_rd_data != expected) begin
        err_flag_d = 1'b1;
        err_cnt_d  = sat_inc(err_cnt_q);
        if (!err_flag_q) begin
          first_err_idx_d  = word_cnt_q;
          first_err_data_d = fifo_rd_data;
        end
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d          = StWaitLvl;
          burst_cnt_d      = '0;
          word_cnt_d       = '0;
          err_flag_d       = 1'b0;
          err_cnt_d        = '0;
          first_err_idx_d  = '0;
          first_err_data_d = '0;
          pat_load         = 1'b1;
        end
      end
      StWaitLvl: begin
        if (fifo_rd_water_level >= BurstLenC) begin
          state_d     = StRead;
          burst_cnt_d = '0;
        end
      end
      StRead: begin
        if (acc) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_d == BurstLenC) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        state_d = (word_cnt_d == TotalWordsC) ? StDone : StWaitLvl;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q          <= StIdle;
      burst_cnt_q      <= '0;
      word_cnt_q       <= '0;
      err_flag_q       <= 1'b0;
      err_cnt_q        <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      chk_busy_q       <= 1'b0;
      chk_done_q       <= 1'b0;
      rd_vld_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      burst_cnt_q      <= burst_cnt_d;
      word_cnt_q       <= word_cnt_d;
      err_flag_q       <= err_flag_d;
      err_cnt_q        <= err_cnt_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      chk_busy_q       <= (state_d == StWaitLvl) || (state_d == StRead) || (state_d == StDrain);
      chk_done_q       <= (state_d == StDone);
      rd_vld_q         <= acc;
    end
  end

  assign chk_busy       = chk_busy_q;
  assign chk_done       = chk_done_q;
  assign err_flag       = err_flag_q;
  assign err_cnt        = err_cnt_q;
  assign word_cnt       = word_cnt_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Bench for ddr_rd_checker: a queue-backed FIFO model feeds two checker instances
// and results are compared with a word-list model of the pattern check.
module tb_ddr_rd_checker;

  localparam int unsigned A_LW = 14;
  localparam int unsigned A_BL = 256;
  localparam int unsigned A_TW = 512;
  localparam logic [15:0] A_PS = 16'h0000;
  localparam int unsigned B_LW = 17;
  localparam int unsigned B_BL = 256;
  localparam int unsigned B_TW = 66304;
  localparam logic [15:0] B_PS = 16'hFFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Instance A: short runs from pattern 0.
  logic            a_rst = 1'b1, a_start = 1'b0, a_rd_en, a_busy, a_done, a_eflag;
  logic            a_empty = 1'b1, a_force = 1'b0;
  logic [15:0]     a_data = '0, a_ecnt, a_fdata;
  logic [A_LW-1:0] a_level = '0;
  logic [A_LW:0]   a_wcnt, a_fidx;
  logic [15:0]     a_q[$];
  int              a_pops = 0;

  // Instance B: long run from 16'hFFFE for wrap and saturation.
  logic            b_rst = 1'b1, b_start = 1'b0, b_rd_en, b_busy, b_done, b_eflag;
  logic            b_empty = 1'b1;
  logic [15:0]     b_data = '0, b_ecnt, b_fdata;
  logic [B_LW-1:0] b_level = '0;
  logic [B_LW:0]   b_wcnt, b_fidx;
  logic [15:0]     b_q[$];

  ddr_rd_checker #(
    .DATA_WIDTH(16), .LEVEL_WIDTH(A_LW), .BURST_LEN(A_BL), .TOTAL_WORDS(A_TW),
    .PATTERN_START(A_PS)
  ) dut_a (
    .rd_clk(clk), .rd_rst(a_rst), .start(a_start), .fifo_rd_en(a_rd_en),
    .fifo_rd_data(a_data), .fifo_rd_empty(a_empty), .fifo_rd_water_level(a_level),
    .chk_busy(a_busy), .chk_done(a_done), .err_flag(a_eflag), .err_cnt(a_ecnt),
    .word_cnt(a_wcnt), .first_err_idx(a_fidx), .first_err_data(a_fdata)
  );

  ddr_rd_checker #(
    .DATA_WIDTH(16), .LEVEL_WIDTH(B_LW), .BURST_LEN(B_BL), .TOTAL_WORDS(B_TW),
    .PATTERN_START(B_PS)
  ) dut_b (
    .rd_clk(clk), .rd_rst(b_rst), .start(b_start), .fifo_rd_en(b_rd_en),
    .fifo_rd_data(b_data), .fifo_rd_empty(b_empty), .fifo_rd_water_level(b_level),
    .chk_busy(b_busy), .chk_done(b_done), .err_flag(b_eflag), .err_cnt(b_ecnt),
    .word_cnt(b_wcnt), .first_err_idx(b_fidx), .first_err_data(b_fdata)
  );

  // FIFO models: flags refresh on the falling edge, reads pop on the rising edge.
  always @(negedge clk) begin
    a_empty <= a_force || (a_q.size() == 0);
    a_level <= A_LW'(a_q.size());
    b_empty <= (b_q.size() == 0);
    b_level <= B_LW'(b_q.size());
  end

  always @(posedge clk) begin
    if (a_rd_en && !a_empty && a_q.size() > 0) begin
      a_data <= a_q.pop_front();
      a_pops <= a_pops + 1;
    end
    if (b_rd_en && !b_empty && b_q.size() > 0) begin
      b_data <= b_q.pop_front();
    end
  end

  logic [15:0] run_d[$];
  int          m_ecnt, m_fidx;
  bit          m_flag;
  logic [15:0] m_fdata;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic gen_run(input int n, input logic [15:0] ps, input int err_permille);
    logic [15:0] w;
    run_d.delete();
    for (int i = 0; i < n; i++) begin
      w = 16'(ps + i);
      if ($urandom_range(999) < err_permille) w = w ^ 16'($urandom_range(65535, 1));
      run_d.push_back(w);
    end
  endtask

  // Word i of a run should equal start + i modulo 2^16; mismatches saturate at 65535.
  task automatic compute_model(input logic [15:0] ps);
    m_ecnt = 0; m_flag = 0; m_fidx = 0; m_fdata = '0;
    for (int i = 0; i < run_d.size(); i++) begin
      logic [15:0] e;
      e = 16'(ps + i);
      if (run_d[i] !== e) begin
        if (!m_flag) begin
          m_fidx  = i;
          m_fdata = run_d[i];
        end
        m_flag = 1;
        if (m_ecnt < 65535) m_ecnt++;
      end
    end
  endtask

  task automatic push_run_a();
    foreach (run_d[i]) a_q.push_back(run_d[i]);
  endtask

  task automatic pulse_start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (!a_done && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (!a_done) $display("FAIL %s_timeout: chk_done=%0b after %0d cycles, need 1", tag, a_done, n);
    else passed++;
  endtask

  task automatic wait_pops_a(input int target, input string tag);
    int n = 0;
    while (a_pops < target && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (a_pops < target) $display("FAIL %s_pops: got %0d reads, need %0d", tag, a_pops, target);
    else passed++;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({a_busy, a_done, a_eflag, a_ecnt, a_wcnt, a_fidx, a_fdata, a_rd_en} !== '0)
      $display("FAIL reset_a: busy=%0b done=%0b flag=%0b ecnt=%0h wcnt=%0d rd_en=%0b, need all 0",
               a_busy, a_done, a_eflag, a_ecnt, a_wcnt, a_rd_en);
    else passed++;
    checks++;
    if ({b_busy, b_done, b_eflag, b_ecnt, b_wcnt, b_fidx, b_fdata, b_rd_en} !== '0)
      $display("FAIL reset_b: busy=%0b done=%0b flag=%0b ecnt=%0h wcnt=%0d, need all 0",
               b_busy, b_done, b_eflag, b_ecnt, b_wcnt);
    else passed++;
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({a_busy, a_done, a_rd_en} !== 3'b000)
      $display("FAIL idle_a: busy/done/rd_en=%b, need 000", {a_busy, a_done, a_rd_en});
    else passed++;
  endtask

  task automatic test_clean();
    gen_run(A_TW, A_PS, 0);
    compute_model(A_PS);
    push_run_a();
    tick();
    pulse_start_a();
    checks++;
    if (a_busy !== 1'b1) $display("FAIL clean_busy: got %0b, need 1", a_busy);
    else passed++;
    wait_done_a("clean");
    checks++;
    if (a_eflag !== 1'b0 || a_ecnt !== 16'd0) $display("FAIL clean_err: flag=%0b cnt=%0d, need 0/0", a_eflag, a_ecnt);
    else passed++;
    checks++;
    if (a_wcnt !== (A_LW + 1)'(A_TW)) $display("FAIL clean_wcnt: got %0d, need %0d", a_wcnt, A_TW);
    else passed++;
    checks++;
    if (a_busy !== 1'b0 || a_fidx !== '0 || a_fdata !== '0)
      $display("FAIL clean_idle: busy=%0b fidx=%0d fdata=%0h, need 0", a_busy, a_fidx, a_fdata);
    else passed++;
  endtask

  task automatic test_single_error();
    gen_run(A_TW, A_PS, 0);
    run_d[300] = 16'h1234;
    compute_model(A_PS);
    push_run_a();
    tick();
    pulse_start_a();
    wait_done_a("single");
    checks++;
    if (a_ecnt !== 16'(m_ecnt) || a_eflag !== 1'b1)
      $display("FAIL single_cnt: cnt=%0d flag=%0b, need %0d/1", a_ecnt, a_eflag, m_ecnt);
    else passed++;
    checks++;
    if (a_fidx !== (A_LW + 1)'(m_fidx)) $display("FAIL single_idx: got %0d, need %0d", a_fidx, m_fidx);
    else passed++;
    checks++;
    if (a_fdata !== m_fdata) $display("FAIL single_data: got %h, need %h", a_fdata, m_fdata);
    else passed++;
    // Results must hold while parked in the done state.
    repeat (5) tick();
    checks++;
    if (a_done !== 1'b1 || a_ecnt !== 16'(m_ecnt) || a_wcnt !== (A_LW + 1)'(A_TW))
      $display("FAIL single_hold: done=%0b cnt=%0d wcnt=%0d", a_done, a_ecnt, a_wcnt);
    else passed++;
  endtask

  task automatic test_level_stall();
    int base, p0;
    gen_run(A_TW, A_PS, 0);
    for (int i = 0; i < A_BL - 1; i++) a_q.push_back(run_d[i]);
    base = a_pops;
    tick();
    pulse_start_a();
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (a_rd_en !== 1'b0) $display("FAIL stall_rd_en: cycle %0d rd_en=%0b level=%0d, need 0", c, a_rd_en, a_level);
      else passed++;
      if (c == 10) pulse_start_a();
    end
    checks++;
    if (a_pops !== base || a_busy !== 1'b1)
      $display("FAIL stall_reads: reads=%0d busy=%0b, need 0/1", a_pops - base, a_busy);
    else passed++;
    for (int i = A_BL - 1; i < A_TW; i++) a_q.push_back(run_d[i]);
    wait_pops_a(base + 40, "stall");
    a_force = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) p0 = a_pops;
      checks++;
      if (a_rd_en !== 1'b0) $display("FAIL empty_rd_en: empty cycle %0d rd_en=%0b, need 0", k, a_rd_en);
      else passed++;
      if (k == 5) a_force = 1'b0;
    end
    tick();
    checks++;
    if (a_rd_en !== 1'b1 || a_pops !== p0)
      $display("FAIL empty_resume: rd_en=%0b reads_during_empty=%0d, need 1/0", a_rd_en, a_pops - p0);
    else passed++;
    wait_done_a("stall");
    checks++;
    if (a_ecnt !== 16'd0 || a_wcnt !== (A_LW + 1)'(A_TW) || (a_pops - base) != A_TW)
      $display("FAIL stall_result: ecnt=%0d wcnt=%0d reads=%0d, need 0/%0d/%0d",
               a_ecnt, a_wcnt, a_pops - base, A_TW, A_TW);
    else passed++;
  endtask

  task automatic test_start_ignored();
    int base;
    logic [A_LW:0] w0;
    gen_run(A_TW, A_PS, 25);
    compute_model(A_PS);
    push_run_a();
    base = a_pops;
    tick();
    pulse_start_a();
    wait_pops_a(base + 150, "ign");
    w0 = a_wcnt;
    pulse_start_a();
    tick();
    checks++;
    if (a_busy !== 1'b1 || a_wcnt < w0 || a_rd_en !== 1'b1)
      $display("FAIL ign_mid: busy=%0b wcnt=%0d (was %0d) rd_en=%0b", a_busy, a_wcnt, w0, a_rd_en);
    else passed++;
    wait_done_a("ign");
    checks++;
    if (a_ecnt !== 16'(m_ecnt) || a_wcnt !== (A_LW + 1)'(A_TW) || a_eflag !== m_flag)
      $display("FAIL ign_result: ecnt=%0d wcnt=%0d flag=%0b, need %0d/%0d/%0b",
               a_ecnt, a_wcnt, a_eflag, m_ecnt, A_TW, m_flag);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int base;
    gen_run(A_TW, A_PS, 0);
    run_d[10] = run_d[10] ^ 16'h0001;
    push_run_a();
    base = a_pops;
    tick();
    pulse_start_a();
    wait_pops_a(base + 100, "rstmid");
    checks++;
    if (a_eflag !== 1'b1) $display("FAIL rstmid_pre: flag=%0b, need 1", a_eflag);
    else passed++;
    a_rst = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_done, a_eflag, a_ecnt, a_wcnt, a_fidx, a_fdata, a_rd_en} !== '0)
      $display("FAIL rstmid_async: busy=%0b flag=%0b ecnt=%0d wcnt=%0d rd_en=%0b, need 0",
               a_busy, a_eflag, a_ecnt, a_wcnt, a_rd_en);
    else passed++;
    tick();
    checks++;
    if ({a_busy, a_done, a_eflag, a_ecnt, a_wcnt, a_fidx, a_fdata, a_rd_en} !== '0)
      $display("FAIL rstmid_edge: busy=%0b flag=%0b ecnt=%0d wcnt=%0d, need 0", a_busy, a_eflag, a_ecnt, a_wcnt);
    else passed++;
    a_rst = 1'b0;
    a_q.delete();
    tick();
    tick();
    gen_run(A_TW, A_PS, 30);
    compute_model(A_PS);
    push_run_a();
    tick();
    pulse_start_a();
    wait_done_a("rerun");
    checks++;
    if (a_ecnt !== 16'(m_ecnt) || a_wcnt !== (A_LW + 1)'(A_TW) || a_fidx !== (A_LW + 1)'(m_fidx))
      $display("FAIL rerun_result: ecnt=%0d wcnt=%0d fidx=%0d, need %0d/%0d/%0d",
               a_ecnt, a_wcnt, a_fidx, m_ecnt, A_TW, m_fidx);
    else passed++;
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 3; r++) begin
      gen_run(A_TW, A_PS, 5 + r * 200);
      compute_model(A_PS);
      push_run_a();
      tick();
      pulse_start_a();
      wait_done_a("rand");
      checks++;
      if (a_ecnt !== 16'(m_ecnt) || a_eflag !== m_flag)
        $display("FAIL rand%0d_cnt: ecnt=%0d flag=%0b, need %0d/%0b", r, a_ecnt, a_eflag, m_ecnt, m_flag);
      else passed++;
      checks++;
      if (a_fidx !== (A_LW + 1)'(m_fidx) || a_fdata !== m_fdata)
        $display("FAIL rand%0d_first: idx=%0d data=%h, need %0d/%h", r, a_fidx, a_fdata, m_fidx, m_fdata);
      else passed++;
    end
  endtask

  task automatic test_wrap_saturate();
    int n;
    gen_run(B_TW, B_PS, 0);
    for (int i = 512; i < B_TW; i++) run_d[i] = run_d[i] ^ 16'($urandom_range(65535, 1));
    compute_model(B_PS);
    foreach (run_d[i]) b_q.push_back(run_d[i]);
    tick();
    tick();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0;
    while (b_wcnt !== (B_LW + 1)'(512) && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (b_wcnt !== (B_LW + 1)'(512)) $display("FAIL wrap_progress: wcnt=%0d, need 512", b_wcnt);
    else passed++;
    checks++;
    if (b_eflag !== 1'b0 || b_ecnt !== 16'd0)
      $display("FAIL wrap_clean: flag=%0b ecnt=%0d after 512 words, need 0/0", b_eflag, b_ecnt);
    else passed++;
    n = 0;
    while (!b_done && n < 70000) begin
      tick();
      n++;
    end
    checks++;
    if (b_done !== 1'b1) $display("FAIL sat_timeout: chk_done=%0b after %0d cycles, need 1", b_done, n);
    else passed++;
    checks++;
    if (b_ecnt !== 16'(m_ecnt)) $display("FAIL sat_cnt: got %h, need %h", b_ecnt, 16'(m_ecnt));
    else passed++;
    checks++;
    if (b_fidx !== (B_LW + 1)'(m_fidx) || b_fdata !== m_fdata || b_eflag !== 1'b1)
      $display("FAIL sat_first: idx=%0d data=%h flag=%0b, need %0d/%h/1", b_fidx, b_fdata, b_eflag, m_fidx, m_fdata);
    else passed++;
    checks++;
    if (b_wcnt !== (B_LW + 1)'(B_TW)) $display("FAIL sat_wcnt: got %0d, need %0d", b_wcnt, B_TW);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_level_stall();
    test_start_ignored();
    test_reset_mid();
    test_random_runs();
    test_wrap_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
